// File: rtl/hazard_controller.sv
// Hazard controller: load-use, memory-wait and redirect sequencing.
// Optional perf counters under HAZARD_CTRL_PERF_EN.
module hazard_controller #(
  parameter int CORE         = 0,
  parameter int ADDRESS_BITS = 20,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    dec_valid,
  input  logic [4:0]              dec_rs1,
  input  logic [4:0]              dec_rs2,
  input  logic                    dec_uses_rs1,
  input  logic                    dec_uses_rs2,
  input  logic [4:0]              ex_rd,
  input  logic [6:0]              ex_opcode,
  input  logic                    ex_redirect,
  input  logic [ADDRESS_BITS-1:0] ex_target,
  input  logic                    mem_busy,
  output logic                    stall_fetch,
  output logic                    stall_decode,
  output logic                    bubble_decode,
  output logic                    flush_fetch,
  output logic                    pc_redirect,
  output logic [ADDRESS_BITS-1:0] pc_target,
  output logic [1:0]              state
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]    stall_cycles,
  output logic [CNT_WIDTH-1:0]    flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDUSE   = 2'd1,
    MEMWAIT = 2'd2,
    FLUSH   = 2'd3
  } state_e;

  if (CORE < 0) begin : g_core_chk
    $error("CORE must be non-negative");
  end

  state_e state_q, state_d;
  logic   load_use;

  assign load_use = (ex_opcode == 7'b0000011) && (ex_rd != 5'd0) &&
                    dec_valid &&
                    ((dec_uses_rs1 && dec_rs1 == ex_rd) ||
                     (dec_uses_rs2 && dec_rs2 == ex_rd));

  always_comb begin
    state_d       = state_q;
    stall_fetch   = 1'b0;
    stall_decode  = 1'b0;
    bubble_decode = 1'b0;
    flush_fetch   = 1'b0;
    pc_redirect   = 1'b0;
    pc_target     = '0;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
          state_d      = MEMWAIT;
        end else if (ex_redirect) begin
          pc_redirect   = 1'b1;
          pc_target     = ex_target;
          flush_fetch   = 1'b1;
          bubble_decode = 1'b1;
          state_d       = FLUSH;
        end else if (load_use) begin
          stall_fetch   = 1'b1;
          bubble_decode = 1'b1;
          state_d       = LDUSE;
        end
      end
      LDUSE: begin
        if (mem_busy) begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
          state_d      = MEMWAIT;
        end else begin
          state_d = RUN;
        end
      end
      MEMWAIT: begin
        // decode buffer is frozen; a held redirect is taken back in RUN
        if (mem_busy) begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        flush_fetch = 1'b1;
        if (mem_busy) begin
          stall_fetch  = 1'b1;
          stall_decode = 1'b1;
        end else begin
          bubble_decode = 1'b1;
          state_d       = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  assign state = state_q;

`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_WIDTH-1:0] stall_q, flush_q;
  logic                 flush_evt;

  assign flush_evt = (state_q == RUN) && (state_d == FLUSH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_fetch && !(&stall_q)) stall_q <= stall_q + CNT_WIDTH'(1);
      if (flush_evt && !(&flush_q))   flush_q <= flush_q + CNT_WIDTH'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Table-driven bench for hazard_controller with expected-result queue.
// Perf build uses a 3-bit counter width so saturation is reached.
module tb_hazard_controller;

  localparam int AW = 20;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          dec_valid;
  logic [4:0]    dec_rs1, dec_rs2;
  logic          dec_uses_rs1, dec_uses_rs2;
  logic [4:0]    ex_rd;
  logic [6:0]    ex_opcode;
  logic          ex_redirect;
  logic [AW-1:0] ex_target;
  logic          mem_busy;
  logic          stall_fetch, stall_decode, bubble_decode;
  logic          flush_fetch, pc_redirect;
  logic [AW-1:0] pc_target;
  logic [1:0]    state;
`ifdef HAZARD_CTRL_PERF_EN
  logic [CW-1:0] stall_cycles, flush_count;
`endif

  hazard_controller #(
    .CORE(0), .ADDRESS_BITS(AW), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .mem_busy(mem_busy),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .bubble_decode(bubble_decode), .flush_fetch(flush_fetch),
    .pc_redirect(pc_redirect), .pc_target(pc_target),
    .state(state)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          busy;
    logic          redir;
    logic [AW-1:0] tgt;
    logic [1:0]    lu;
    logic [4:0]    eo;
    logic [AW-1:0] ept;
    logic [1:0]    est;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic b, logic r, logic [AW-1:0] t,
                              logic [1:0] l, logic [4:0] eo,
                              logic [AW-1:0] pt, logic [1:0] st);
    vec_t v;
    v.busy = b; v.redir = r; v.tgt = t; v.lu = l;
    v.eo = eo; v.ept = pt; v.est = st;
    return v;
  endfunction

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // 0: ALU op, 1: load hit via rs1, 2: load to x0, 3: load hit via rs2
  task automatic set_lu(logic [1:0] l);
    dec_valid = 1'b1; dec_uses_rs2 = 1'b0; dec_rs2 = 5'd0;
    dec_uses_rs1 = 1'b1;
    case (l)
      2'd0: begin ex_opcode = 7'h33; ex_rd = 5'd5; dec_rs1 = 5'd5; end
      2'd1: begin ex_opcode = 7'h03; ex_rd = 5'd5; dec_rs1 = 5'd5; end
      2'd2: begin ex_opcode = 7'h03; ex_rd = 5'd0; dec_rs1 = 5'd0; end
      default: begin
        ex_opcode = 7'h03; ex_rd = 5'd7; dec_rs1 = 5'd1;
        dec_rs2 = 5'd7; dec_uses_rs2 = 1'b1;
      end
    endcase
  endtask

  function automatic logic [4:0] outs();
    return {stall_fetch, stall_decode, bubble_decode,
            flush_fetch, pc_redirect};
  endfunction

  initial begin
    vec_t e;
    reset = 1'b0; mem_busy = 1'b0; ex_redirect = 1'b0;
    ex_target = '0; set_lu(2'd0); dec_valid = 1'b0;
    ex_opcode = 7'h00; ex_rd = 5'd0; dec_rs1 = 5'd0;
    dec_uses_rs1 = 1'b0;
    #12;
    check("reset_outs", int'(outs()), 0);
    check("reset_state", int'(state), 0);
    check("reset_pct", int'(pc_target), 0);
`ifdef HAZARD_CTRL_PERF_EN
    check("reset_stallcnt", int'(stall_cycles), 0);
    check("reset_flushcnt", int'(flush_count), 0);
`endif
    reset = 1'b1;
    @(posedge clock); #1;

    // {sf,sd,bd,ff,pr}
    vecs.push_back(mk(0, 0, 0,        0, 5'b00000, 0,        0));
    vecs.push_back(mk(0, 0, 0,        1, 5'b10100, 0,        0));
    vecs.push_back(mk(0, 0, 0,        1, 5'b00000, 0,        1));
    vecs.push_back(mk(0, 0, 0,        0, 5'b00000, 0,        0));
    vecs.push_back(mk(0, 0, 0,        2, 5'b00000, 0,        0));
    vecs.push_back(mk(0, 1, 'h00040,  0, 5'b00111, 'h00040,  0));
    vecs.push_back(mk(0, 0, 0,        0, 5'b00110, 0,        3));
    vecs.push_back(mk(0, 0, 0,        0, 5'b00000, 0,        0));
    vecs.push_back(mk(1, 0, 0,        0, 5'b11000, 0,        0));
    vecs.push_back(mk(1, 1, 'h00040,  0, 5'b11000, 0,        2));
    vecs.push_back(mk(1, 1, 'h00040,  0, 5'b11000, 0,        2));
    vecs.push_back(mk(0, 1, 'h00040,  0, 5'b00000, 0,        2));
    vecs.push_back(mk(0, 1, 'h00040,  0, 5'b00111, 'h00040,  0));
    vecs.push_back(mk(1, 0, 0,        0, 5'b11010, 0,        3));
    vecs.push_back(mk(0, 0, 0,        0, 5'b00110, 0,        3));
    vecs.push_back(mk(1, 1, 'h00123,  1, 5'b11000, 0,        0));
    vecs.push_back(mk(0, 0, 0,        0, 5'b00000, 0,        2));
    vecs.push_back(mk(0, 1, 'hABCDE,  3, 5'b00111, 'hABCDE,  0));
    vecs.push_back(mk(0, 0, 0,        0, 5'b00110, 0,        3));
    vecs.push_back(mk(0, 0, 0,        3, 5'b10100, 0,        0));
    vecs.push_back(mk(1, 0, 0,        0, 5'b11000, 0,        1));
    vecs.push_back(mk(0, 0, 0,        0, 5'b00000, 0,        2));
    vecs.push_back(mk(0, 0, 0,        0, 5'b00000, 0,        0));

    for (int i = 0; i < vecs.size(); i++) begin
      mem_busy = vecs[i].busy;
      ex_redirect = vecs[i].redir;
      ex_target = vecs[i].tgt;
      set_lu(vecs[i].lu);
      exp_q.push_back(vecs[i]);
      @(negedge clock);
      e = exp_q.pop_front();
      check($sformatf("v%0d_outs", i), int'(outs()), int'(e.eo));
      check($sformatf("v%0d_pct", i), int'(pc_target), int'(e.ept));
      check($sformatf("v%0d_state", i), int'(state), int'(e.est));
      @(posedge clock); #1;
    end

`ifdef HAZARD_CTRL_PERF_EN
    check("stallcnt_sat", int'(stall_cycles), 7);
    check("flushcnt", int'(flush_count), 3);
`endif

    // reset asserted mid-flush with memory busy
    set_lu(2'd0); mem_busy = 1'b0;
    ex_redirect = 1'b1; ex_target = 'h00100;
    @(negedge clock);
    check("rst_seq_redir", int'(outs()), 5'b00111);
    @(posedge clock); #1;
    ex_redirect = 1'b0; ex_target = '0; mem_busy = 1'b1;
    @(negedge clock);
    check("rst_seq_flushbusy", int'(outs()), 5'b11010);
    check("rst_seq_st3", int'(state), 3);
    #2 reset = 1'b0;
    #1;
    check("rst_async_state", int'(state), 0);
    check("rst_async_outs", int'(outs()), 5'b11000);
`ifdef HAZARD_CTRL_PERF_EN
    check("rst_async_stallcnt", int'(stall_cycles), 0);
    check("rst_async_flushcnt", int'(flush_count), 0);
`endif
    mem_busy = 1'b0;
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst_after_state", int'(state), 0);
    check("rst_after_outs", int'(outs()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and sequencing controller for the fetch → decode → decode_buffer → execute path of the pipelined core. Each cycle it decides whether the decode buffer captures the decoded instruction, holds its contents, or loads a bubble. It also decides whether fetch holds or is flushed, and when the PC is redirected. It resolves load-use hazards, data-memory wait stalls and taken control transfers (branch/JAL/JALR) from execute.

## Interface
Parameters:
- CORE, 0, core index (informational only).
- ADDRESS_BITS, 20, instruction address width.
- CNT_WIDTH, 32, width of the performance counters.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- dec_valid  in  1  decode stage holds a valid instruction.
- dec_rs1, dec_rs2  in  5 each  decode-stage source register indices.
- dec_uses_rs1, dec_uses_rs2  in  1 each  source operand actually read.
- ex_rd  in  5  destination register held in the decode buffer.
- ex_opcode  in  7  opcode held in the decode buffer.
- ex_redirect  in  1  execute resolved a taken branch, JAL or JALR.
- ex_target  in  ADDRESS_BITS  redirect target from execute.
- mem_busy  in  1  data memory not ready; older stages must hold.
- stall_fetch  out  1  PC and fetch register hold.
- stall_decode  out  1  decode buffer holds its contents.
- bubble_decode  out  1  decode buffer loads a NOP (opcode 7'h13, rd 0).
- flush_fetch  out  1  fetch-stage instruction is killed (marked invalid).
- pc_redirect  out  1  PC loads pc_target this edge.
- pc_target  out  ADDRESS_BITS  redirect address.
- state  out  2  current FSM state, for debug.
- stall_cycles, flush_count  out  CNT_WIDTH each  present only with HAZARD_CTRL_PERF_EN.

## Operation
- FSM states: RUN=0, LDUSE=1, MEMWAIT=2, FLUSH=3. The state is registered; all control outputs are combinational from the state and the current inputs.
- load_use = (ex_opcode==7'b0000011) && ex_rd!=0 && dec_valid && ((dec_uses_rs1 && dec_rs1==ex_rd) || (dec_uses_rs2 && dec_rs2==ex_rd)).
- RUN uses the following priority. If several apply, only the highest one acts.
  - mem_busy: stall_fetch=stall_decode=1; next state MEMWAIT.
  - else ex_redirect: pc_redirect=1, pc_target=ex_target, flush_fetch=1, bubble_decode=1; next state FLUSH.
  - else load_use: stall_fetch=1, bubble_decode=1; next state LDUSE.
  - else all outputs 0; stay in RUN.
- LDUSE: load_use detection is suppressed. If mem_busy, act as in RUN and go to MEMWAIT; otherwise all outputs 0 and go to RUN.
- MEMWAIT: while mem_busy, stall_fetch=stall_decode=1. ex_redirect and load_use are ignored because the decode buffer is frozen. When mem_busy=0, all outputs are 0 and the next state is RUN; a held redirect is then taken in RUN.
- FLUSH kills the wrong-path instruction fetched during the redirect edge.
  - mem_busy=0: flush_fetch=1, bubble_decode=1; next state RUN.
  - mem_busy=1: stall_fetch=stall_decode=1, flush_fetch=1; stay in FLUSH.
- pc_target equals ex_target whenever pc_redirect=1 and is 0 otherwise.
- stall_decode and bubble_decode are never asserted together.

## Timing
- Async reset (reset=0) immediately forces state=RUN and counters=0. With state RUN and all inputs 0, every control output is 0.
- A reset asserted mid-stall or mid-flush aborts the stall or flush; no pending redirect is retained.
- Load-use costs exactly 1 bubble cycle. A taken redirect costs 2 bubble cycles: the redirect cycle plus FLUSH. A memory wait costs one held cycle per cycle of mem_busy.
- Decisions take 0 cycles of latency: outputs respond in the same cycle as the inputs. Only the state advances on the rising edge.

## Configuration
- HAZARD_CTRL_PERF_EN defined:
  - stall_cycles increments on every cycle with stall_fetch=1.
  - flush_count increments on every RUN→FLUSH transition.
  - Both counters saturate at all-ones and reset to 0.
- Not defined: both counter ports and their logic are absent; all other behaviour is identical.

## Test plan
- Load-use: ex_opcode=7'h03, ex_rd=5, dec_rs1=5, dec_uses_rs1=1 in RUN → stall_fetch=1 and bubble_decode=1 for exactly 1 cycle, then state LDUSE, then RUN with outputs 0. Repeat with ex_rd=0 → no stall.
- Taken branch: ex_redirect=1, ex_target=20'h00040 → pc_redirect=1 with pc_target=20'h00040, flush_fetch=1 and bubble_decode=1 that cycle, then FLUSH with flush_fetch=1 for 1 cycle, then RUN.
- Memory wait: mem_busy high for 3 cycles from RUN → stall_fetch=stall_decode=1 for 3 cycles, MEMWAIT entered, RUN on the 4th cycle. A concurrent ex_redirect is taken only on the first RUN cycle.
- Simultaneous events: mem_busy=1, ex_redirect=1 and load_use true together → only the stall outputs assert. Then ex_redirect=1 with load_use → redirect wins, no LDUSE.
- Reset mid-operation: in FLUSH with mem_busy=1, assert reset=0 asynchronously between edges → state=RUN immediately and counters=0.
- Perf counters (HAZARD_CTRL_PERF_EN): 1 load-use, 1 redirect and 3 busy cycles → stall_cycles=4, flush_count=1. Preload near all-ones and verify saturation.
